// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_pkg
// Description : Shared types and encodings for the multi-cycle RISC-V main
//               control FSM: state enumeration, RV32I opcodes and the select
//               encodings driven towards the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_beq  = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;

    // ALU A operand select
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    // Result select
    localparam logic [1:0] c_res_aluout  = 2'b00;
    localparam logic [1:0] c_res_memdata = 2'b01;
    localparam logic [1:0] c_res_alures  = 2'b10;

    // ALU-control operation class
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

endpackage
`default_nettype wire

// File: rtl/riscv_mc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_control_if
// Description : Bundle between the main control FSM and the datapath.
//               master  : the control FSM (consumes opcode/zero/mem_ready,
//                         drives every control and instret)
//               slave   : the datapath / memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mc_control_if;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_en;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  aluop;
    logic        imm_op;
    logic [1:0]  result_src;
    logic        reg_write;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_en,
               alu_src_a, alu_src_b, aluop, imm_op, result_src,
               reg_write, illegal, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_en,
               alu_src_a, alu_src_b, aluop, imm_op, result_src,
               reg_write, illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mc_control_instret_counter.sv
`default_nettype none
// ============================================================================
// Module      : instret_counter
// Description : 32-bit retired-instruction counter, wraps 0xFFFFFFFF -> 0.
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (loads RST_VALUE)
//   i_inc    in   count enable, one increment per enabled cycle
//   o_count  out  current count
// Revision    : 1.0 - initial release
// ============================================================================
module instret_counter #(
    parameter logic [31:0] RST_VALUE = 32'd0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_inc,
    output logic [31:0]      o_count
);

    logic [31:0] r_count;

    // Natural modulo-2^32 addition gives the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_VALUE;
        end else if (i_inc) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/riscv_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_control
// Description : Multi-cycle main control FSM. Sequences the shared ALU and
//               the unified memory port through FETCH/DECODE/EXECUTE/MEM/
//               WRITEBACK, drives aluop for the ALU-control decoder and keeps
//               a retired-instruction counter.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   bus    master modport: opcode/zero/mem_ready in; memory handshake,
//          datapath selects/enables, illegal and instret out
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_control
    import riscv_mc_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    riscv_mc_control_if.master bus
);

    state_t r_state;
    state_t w_next;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_aluop;
    logic       w_imm_op;
    logic [1:0] w_result_src;
    logic       w_reg_write;
    logic       w_retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_alu_src_a  = c_srca_pc;
        w_alu_src_b  = c_srcb_rs2;
        w_aluop      = c_aluop_add;
        w_imm_op     = 1'b0;
        w_result_src = c_res_aluout;
        w_reg_write  = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 is written back the same cycle the instruction lands.
                w_mem_req    = 1'b1;
                w_alu_src_a  = c_srca_pc;
                w_alu_src_b  = c_srcb_four;
                w_result_src = c_res_alures;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch/jump target OldPC+imm into ALUOut.
                w_alu_src_a = c_srca_oldpc;
                w_alu_src_b = c_srcb_imm;
                case (bus.opcode)
                    c_op_lw,
                    c_op_sw:  w_next = S_MEMADR;
                    c_op_r:   w_next = S_EXECR;
                    c_op_i:   w_next = S_EXECI;
                    c_op_beq: w_next = S_BEQ;
                    c_op_jal: w_next = S_JAL;
                    default:  w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_src_b = c_srcb_imm;
                w_next      = (bus.opcode == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_result_src = c_res_memdata;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_src_b = c_srcb_rs2;
                w_aluop     = c_aluop_funct;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_src_b = c_srcb_imm;
                w_aluop     = c_aluop_funct;
                w_imm_op    = 1'b1;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = c_res_aluout;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a  = c_srca_rs1;
                w_alu_src_b  = c_srcb_rs2;
                w_aluop      = c_aluop_sub;
                w_result_src = c_res_aluout;
                w_branch     = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target from ALUOut while the ALU forms
                // OldPC+4, which ALUWB then writes as the link value.
                w_alu_src_a  = c_srca_oldpc;
                w_alu_src_b  = c_srcb_four;
                w_result_src = c_res_aluout;
                w_pc_write   = 1'b1;
                w_next       = S_ALUWB;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Side-effecting strobes are masked while reset is high so that an
    // in-flight memory access is dropped in the same cycle.
    assign bus.mem_req    = w_mem_req & ~reset;
    assign bus.ir_write   = w_ir_write & ~reset;
    assign bus.pc_en      = (w_pc_write | (w_branch & bus.zero)) & ~reset;
    assign bus.reg_write  = w_reg_write & ~reset;
    assign bus.mem_write  = w_mem_write;
    assign bus.adr_src    = w_adr_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.aluop      = w_aluop;
    assign bus.imm_op     = w_imm_op;
    assign bus.result_src = w_result_src;
    assign bus.illegal    = (r_state == S_TRAP);

    instret_counter u_instret (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_retire),
        .o_count (bus.instret)
    );

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mc_control
// Description : Self-checking bench for riscv_mc_control. An instruction-level
//               reference model expands each opcode into its sequence of
//               phases and checks every control output each cycle plus the
//               retire count after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_control;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                   P_ALUWB = 8, P_BEQ = 9, P_JAL = 10, P_TRAP = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrap_inc = 1'b0;
    logic [31:0] wrap_count;
    logic [31:0] exp_instret;
    int          total = 0;
    int          bad = 0;

    riscv_mc_control_if bus();

    riscv_mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    instret_counter #(.RST_VALUE(32'hFFFF_FFFF)) u_wrap (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (wrap_inc),
        .o_count (wrap_count)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_write, adr_src, ir_write, pc_en, a[2], b[2], aluop[2],
    //  imm_op, result_src[2], reg_write, illegal}
    function automatic logic [15:0] expect_vec(int ph, logic mr, logic z, logic rst);
        logic rq, wr, ad, ir, pc, imm, rw, ill;
        logic [1:0] a, b, op, res;
        rq = 0; wr = 0; ad = 0; ir = 0; pc = 0; imm = 0; rw = 0; ill = 0;
        a = 2'b00; b = 2'b00; op = 2'b00; res = 2'b00;
        case (ph)
            P_FETCH:    begin rq = 1; b = 2'b10; res = 2'b10; ir = mr; pc = mr; end
            P_DECODE:   begin a = 2'b01; b = 2'b01; end
            P_MEMADR:   begin a = 2'b10; b = 2'b01; end
            P_MEMREAD:  begin rq = 1; ad = 1; end
            P_MEMWB:    begin res = 2'b01; rw = 1; end
            P_MEMWRITE: begin rq = 1; wr = 1; ad = 1; end
            P_EXECR:    begin a = 2'b10; op = 2'b10; end
            P_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; imm = 1; end
            P_ALUWB:    begin rw = 1; end
            P_BEQ:      begin a = 2'b10; op = 2'b01; pc = z; end
            P_JAL:      begin a = 2'b01; b = 2'b10; pc = 1; end
            P_TRAP:     begin ill = 1; end
            default:    begin ill = 0; end
        endcase
        if (rst) begin
            rq = 0; ir = 0; pc = 0; rw = 0;
        end
        return {rq, wr, ad, ir, pc, a, b, op, imm, res, rw, ill};
    endfunction

    function automatic logic [15:0] observed();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_en,
                bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.imm_op,
                bus.result_src, bus.reg_write, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle spent in phase ph; inputs driven at the falling edge.
    task automatic step(input int ph, input logic mr, input logic z, input string tag);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
        check($sformatf("%s ph%0d ctl", tag, ph), {16'd0, observed()},
              {16'd0, expect_vec(ph, mr, z, 1'b0)});
        @(posedge clk);
        #1;
        if (ph == P_MEMWB || ph == P_ALUWB || ph == P_BEQ || (ph == P_MEMWRITE && mr))
            exp_instret = exp_instret + 32'd1;
        check($sformatf("%s ph%0d instret", tag, ph), bus.instret, exp_instret);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] op, input int wf, input int wm,
                             input logic z, input string tag);
        bus.opcode = op;
        for (int i = 0; i < wf; i++) step(P_FETCH, 1'b0, rb(), tag);
        step(P_FETCH, 1'b1, rb(), tag);
        step(P_DECODE, rb(), rb(), tag);
        case (op)
            7'b0110011: begin step(P_EXECR, rb(), rb(), tag); step(P_ALUWB, rb(), rb(), tag); end
            7'b0010011: begin step(P_EXECI, rb(), rb(), tag); step(P_ALUWB, rb(), rb(), tag); end
            7'b0000011: begin
                step(P_MEMADR, rb(), rb(), tag);
                for (int i = 0; i < wm; i++) step(P_MEMREAD, 1'b0, rb(), tag);
                step(P_MEMREAD, 1'b1, rb(), tag);
                step(P_MEMWB, rb(), rb(), tag);
            end
            7'b0100011: begin
                step(P_MEMADR, rb(), rb(), tag);
                for (int i = 0; i < wm; i++) step(P_MEMWRITE, 1'b0, rb(), tag);
                step(P_MEMWRITE, 1'b1, rb(), tag);
            end
            7'b1100011: step(P_BEQ, rb(), z, tag);
            7'b1101111: begin step(P_JAL, rb(), rb(), tag); step(P_ALUWB, rb(), rb(), tag); end
            default:    for (int i = 0; i < 12; i++) step(P_TRAP, rb(), rb(), tag);
        endcase
    endtask

    // Reset asserted at a falling edge, released just after the next rise.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check({tag, " rst ctl"}, {16'd0, observed()}, {16'd0, expect_vec(P_FETCH, 1'b1, 1'b0, 1'b1)});
        @(posedge clk);
        #1;
        exp_instret = 32'd0;
        check({tag, " rst instret"}, bus.instret, exp_instret);
        reset = 1'b0;
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
        legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;
        bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        exp_instret = 32'd0;

        do_reset("init");

        run_instr(7'b0110011, 0, 0, 1'b0, "add");
        run_instr(7'b0000011, 0, 2, 1'b0, "lw_wait");
        run_instr(7'b1100011, 0, 0, 1'b1, "beq_taken");
        run_instr(7'b1100011, 0, 0, 1'b0, "beq_not");
        run_instr(7'b1101111, 0, 0, 1'b0, "jal");
        run_instr(7'b0010011, 0, 0, 1'b0, "addi");
        check("instret after directed", bus.instret, 32'd6);

        for (int n = 0; n < 40; n++)
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), rb(), $sformatf("rnd%0d", n));

        // Reset in the middle of a stalled store: no retire, request dropped.
        bus.opcode = 7'b0100011;
        step(P_FETCH, 1'b1, 1'b0, "sw_abort");
        step(P_DECODE, 1'b0, 1'b0, "sw_abort");
        step(P_MEMADR, 1'b0, 1'b0, "sw_abort");
        step(P_MEMWRITE, 1'b0, 1'b0, "sw_abort");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("abort mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("abort mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("abort instret", bus.instret, 32'd0);
        #1;
        bus.mem_ready = 1'b1;
        #1;
        check("abort ctl ready", {16'd0, observed()}, {16'd0, expect_vec(P_FETCH, 1'b1, 1'b0, 1'b1)});
        @(posedge clk);
        #1;
        exp_instret = 32'd0;
        check("abort instret held", bus.instret, exp_instret);
        reset = 1'b0;

        run_instr(7'b0010011, 1, 0, 1'b0, "post_abort");
        run_instr(7'b1111111, 2, 0, 1'b0, "illegal");
        check("illegal instret", bus.instret, 32'd1);
        do_reset("trap_exit");
        #1;
        check("illegal cleared", {31'd0, bus.illegal}, 32'd0);
        run_instr(7'b0110011, 0, 0, 1'b0, "after_trap");

        // Counter wrap on a standalone instance primed at all-ones.
        do_reset("wrap");
        check("wrap start", wrap_count, 32'hFFFF_FFFF);
        @(negedge clk);
        wrap_inc = 1'b1;
        @(posedge clk);
        #1;
        check("wrap to zero", wrap_count, 32'd0);
        @(posedge clk);
        #1;
        check("wrap plus one", wrap_count, 32'd1);
        wrap_inc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
